// File: rtl/spi_cmd_decoder_if.sv
// Byte-stream and register-file signals between the SPI bridge,
// the command decoder and the register file.
interface spi_cmd_decoder_if;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [6:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       err;

    modport master (
        output cs_n, byte_sync, data_in, rd_data,
        input  data_out, addr, wr_en, wr_data, rd_en, err
    );

    modport slave (
        input  cs_n, byte_sync, data_in, rd_data,
        output data_out, addr, wr_en, wr_data, rd_en, err
    );
endinterface

// File: rtl/spi_cmd_decoder.sv
// Decodes SPI command frames (cmd+data write, cmd+dummy+resp read)
// into register-file strobes and returns read data to the bridge.
module spi_cmd_decoder #(
    parameter logic [6:0] MAX_ADDR = 7'h3F
) (
    input logic clk,
    input logic rst_n,
    spi_cmd_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        CMD,
        WR_DATA,
        RD_DUMMY,
        RD_RESP
    } state_t;

    state_t state;
    logic   mapped_in;
    logic   mapped_cur;

    assign mapped_in  = (bus.data_in[6:0] <= MAX_ADDR);
    assign mapped_cur = (bus.addr <= MAX_ADDR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= CMD;
            bus.data_out <= 8'h00;
            bus.addr     <= 7'h00;
            bus.wr_en    <= 1'b0;
            bus.wr_data  <= 8'h00;
            bus.rd_en    <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            bus.rd_en <= 1'b0;
            bus.err   <= 1'b0;
            if (bus.cs_n) begin
                // Chip select wins over any byte arriving this cycle
                state        <= CMD;
                bus.data_out <= 8'h00;
            end else begin
                if (bus.rd_en) begin
                    bus.data_out <= bus.rd_data;
                end
                if (bus.byte_sync) begin
                    unique case (state)
                        CMD: begin
                            bus.addr <= bus.data_in[6:0];
                            if (bus.data_in[7]) begin
                                state <= WR_DATA;
                            end else begin
                                state <= RD_DUMMY;
                                if (mapped_in) begin
                                    bus.rd_en <= 1'b1;
                                end else begin
                                    bus.err      <= 1'b1;
                                    bus.data_out <= 8'h00;
                                end
                            end
                        end
                        WR_DATA: begin
                            state <= CMD;
                            if (mapped_cur) begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_data <= bus.data_in;
                            end else begin
                                bus.err <= 1'b1;
                            end
                        end
                        RD_DUMMY: begin
                            state <= RD_RESP;
                        end
                        RD_RESP: begin
                            state        <= CMD;
                            bus.data_out <= 8'h00;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Randomized scoreboard bench for spi_cmd_decoder: a frame-level
// model predicts strobes and bridge-loaded bytes; a monitor checks them.
module tb_spi_cmd_decoder;

    localparam logic [6:0] MAX_A = 7'h3F;

    typedef enum int {K_WR, K_RD, K_ERR, K_LOAD} kind_t;
    typedef struct {
        kind_t      kind;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_pulse = 1'b0;

    spi_cmd_decoder_if bus ();

    spi_cmd_decoder #(.MAX_ADDR(MAX_A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rf [0:127];
    logic [7:0] model [0:127];
    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    // frame-level model state: byte position within the current command
    int         pos = 0;
    logic [6:0] cur_a = 7'h00;
    bit         cur_map = 1'b0;

    assign bus.rd_data = rf[bus.addr];

    always @(posedge clk) begin
        if (rst_n && bus.wr_en) rf[bus.addr] <= bus.wr_data;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            int   act;
            exp_t e;
            act = int'(bus.wr_en) + int'(bus.rd_en) + int'(bus.err);
            if (act != 0) begin
                check("one_strobe", act, 1);
                if (q.size() == 0) begin
                    check("unexpected_strobe", act, 0);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind",
                          bus.wr_en ? K_WR : (bus.rd_en ? K_RD : K_ERR),
                          e.kind);
                    check("strobe_addr", bus.addr, e.addr);
                    if (bus.wr_en) check("wr_data", bus.wr_data, e.data);
                end
            end
            if (load_pulse) begin
                if (q.size() == 0) begin
                    check("unexpected_load", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("load_kind", e.kind, K_LOAD);
                    check("data_out", bus.data_out, e.data);
                end
            end
        end
    end

    task automatic push(kind_t k, logic [6:0] a, logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic do_load(logic [7:0] exp);
        push(K_LOAD, 7'h00, exp);
        @(posedge clk); #1 load_pulse = 1'b1;
        @(posedge clk); #1 load_pulse = 1'b0;
    endtask

    task automatic send_byte(logic [7:0] b);
        logic [7:0] ld;
        ld = 8'h00;
        case (pos)
            0: begin
                cur_a   = b[6:0];
                cur_map = (b[6:0] <= MAX_A);
                if (b[7]) begin
                    pos = 1;
                end else begin
                    pos = 2;
                    if (cur_map) begin
                        push(K_RD, cur_a, 8'h00);
                        ld = model[cur_a];
                    end else begin
                        push(K_ERR, cur_a, 8'h00);
                    end
                end
            end
            1: begin
                pos = 0;
                if (cur_map) begin
                    push(K_WR, cur_a, b);
                    model[cur_a] = b;
                end else begin
                    push(K_ERR, cur_a, 8'h00);
                end
            end
            2: begin
                pos = 3;
                if (cur_map) ld = model[cur_a];
            end
            default: pos = 0;
        endcase
        @(posedge clk); #1 bus.byte_sync = 1'b1; bus.data_in = b;
        @(posedge clk); #1 bus.byte_sync = 1'b0;
        @(posedge clk); #1;
        do_load(ld);
        repeat ($urandom_range(0, 6)) @(posedge clk);
    endtask

    task automatic abort(bit with_byte);
        @(posedge clk); #1 bus.cs_n = 1'b1;
        if (with_byte) begin
            bus.byte_sync = 1'b1;
            bus.data_in   = 8'($urandom);
        end
        @(posedge clk); #1 bus.byte_sync = 1'b0;
        @(posedge clk); #1 bus.cs_n = 1'b0;
        pos = 0;
        do_load(8'h00);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_data_out"}, bus.data_out, 0);
        check({tag, "_addr"}, bus.addr, 0);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_rd_en"}, bus.rd_en, 0);
        check({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            rf[i]    = 8'($urandom);
            model[i] = rf[i];
        end
        rf[5]    = 8'h3C;
        model[5] = 8'h3C;
        bus.cs_n      = 1'b1;
        bus.byte_sync = 1'b0;
        bus.data_in   = 8'h00;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;
        bus.cs_n = 1'b0;

        // directed frames from the plan
        send_byte(8'h85); send_byte(8'hA5);
        rf[5] = 8'h3C; model[5] = 8'h3C;
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hC0); send_byte(8'h11);
        send_byte(8'h7F); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h85); abort(1'b0);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h81); send_byte(8'h10);
        send_byte(8'h82); send_byte(8'h20);
        send_byte(8'h91); abort(1'b1);

        // reset while in the dummy-byte state of a read
        send_byte(8'h05);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 check_all_zero("midrst");
        rst_n = 1'b1;
        pos = 0;
        send_byte(8'h81); send_byte(8'h55);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) abort(1'($urandom));
            else send_byte(8'($urandom));
        end

        repeat (5) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
